// File: rtl/ram_pkg.sv
// Shared defaults, legal parameter ranges and index-width helper for the
// arbitrated multi-port RAM.
package ram_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH   = 4;
  localparam int DEF_NUM_PORTS    = 2;
  localparam int DEF_READ_LATENCY = 1;

  localparam int MIN_PORTS        = 1;
  localparam int MAX_PORTS        = 8;
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;

  // Width of a port index; never zero so a single-port build still has a bit.
  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, the search starts
// at the port after the last one granted.
module rr_arbiter
  import ram_pkg::*;
#(
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  localparam int PW        = port_idx_w(NUM_PORTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PW-1:0]        o_grant_idx
);

  logic [PW-1:0] ptr;
  logic [PW:0]   cand;
  logic          found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
      if (!found && i_req[cand[PW-1:0]]) begin
        o_grant[cand[PW-1:0]] = 1'b1;
        o_grant_idx           = cand[PW-1:0];
        found                 = 1'b1;
      end
    end
  end

  // Pointer only advances when something was accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   ptr <= '0;
    else if (found) ptr <= (o_grant_idx == PW'(NUM_PORTS-1)) ? '0 : o_grant_idx + 1'b1;
  end

endmodule

// File: rtl/ram_arb.sv
// Single-ported RAM shared by NUM_PORTS requesters through a round-robin
// arbiter; fully pipelined reads return on the requesting port's o_data slice.
module ram_arb
  import ram_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter  int NUM_PORTS    = DEF_NUM_PORTS,
  parameter  int READ_LATENCY = DEF_READ_LATENCY,
  localparam int BE_WIDTH     = DATA_WIDTH/8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_PORTS-1:0]            i_req,
  input  logic [NUM_PORTS-1:0]            i_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]   i_be,
  output logic [NUM_PORTS-1:0]            o_grant,
  output logic [NUM_PORTS-1:0]            o_done,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] o_data
);

  localparam int PW    = port_idx_w(NUM_PORTS);
  localparam int DEPTH = 2**ADDR_WIDTH;

  if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS ||
      READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY ||
      DATA_WIDTH % 8 != 0) begin : g_bad_cfg
    $error("ram_arb: parameter out of range");
  end

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
  } req_t;

  req_t [NUM_PORTS-1:0] reqs;
  req_t                 sel;
  logic [NUM_PORTS-1:0] grant;
  logic [PW-1:0]        gidx;
  logic                 acc, acc_wr, acc_rd;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign reqs[p] = '{wr:   i_write[p],
                       addr: i_address[p*ADDR_WIDTH +: ADDR_WIDTH],
                       data: i_data[p*DATA_WIDTH +: DATA_WIDTH],
                       be:   i_be[p*BE_WIDTH +: BE_WIDTH]};
  end

  // Requests are masked in reset so nothing is accepted at an edge while
  // the pipeline is being cleared.
  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req & {NUM_PORTS{i_rst_n}}),
    .o_grant     (grant),
    .o_grant_idx (gidx)
  );

  assign o_grant = grant;
  assign sel     = reqs[gidx];
  assign acc     = |grant;
  assign acc_wr  = acc & sel.wr;
  assign acc_rd  = acc & ~sel.wr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (acc_wr) begin
      for (int b = 0; b < BE_WIDTH; b++)
        if (sel.be[b]) mem[sel.addr][b*8 +: 8] <= sel.data[b*8 +: 8];
    end
  end

  // Read pipeline: stage 1 is the RAM output register, the port index rides along.
  logic [DATA_WIDTH-1:0] dat_q [1:READ_LATENCY];
  logic [PW-1:0]         idx_q [1:READ_LATENCY];
  logic [READ_LATENCY:1] vld_q;
  logic [READ_LATENCY:0] vld_pipe;
  logic [NUM_PORTS-1:0]  rd_done, wr_done_q;

  always_ff @(posedge i_clk) begin
    if (acc_rd) dat_q[1] <= mem[sel.addr];
    idx_q[1] <= gidx;
    for (int k = 2; k <= READ_LATENCY; k++) begin
      dat_q[k] <= dat_q[k-1];
      idx_q[k] <= idx_q[k-1];
    end
  end

  assign vld_pipe = {vld_q, acc_rd};

  always_comb begin
    rd_done = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (vld_pipe[READ_LATENCY] && idx_q[READ_LATENCY] == PW'(p)) rd_done[p] = 1'b1;
  end

  // Write and read completions for one port in the same cycle fold into one pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q     <= '0;
      wr_done_q <= '0;
      o_done    <= '0;
      o_data    <= '0;
    end else begin
      vld_q     <= vld_pipe[READ_LATENCY-1:0];
      wr_done_q <= acc_wr ? grant : '0;
      o_done    <= wr_done_q | rd_done;
      for (int p = 0; p < NUM_PORTS; p++)
        if (rd_done[p]) o_data[p*DATA_WIDTH +: DATA_WIDTH] <= dat_q[READ_LATENCY];
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: a vector table on an 8-bit/2-port/latency-1 instance,
// directed sequences and a randomized model run on a 32-bit/3-port/latency-3 instance.
module tb_ram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [1:0]  req8, wr8, be8, grant8, done8;
  logic [7:0]  addr8;
  logic [15:0] data8, q8;

  ram_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_PORTS(2), .READ_LATENCY(1)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req8), .i_write(wr8), .i_address(addr8),
    .i_data(data8), .i_be(be8), .o_grant(grant8), .o_done(done8), .o_data(q8));

  logic [2:0]  req32, wr32, grant32, done32;
  logic [11:0] addr32, be32;
  logic [95:0] data32, q32;

  ram_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_PORTS(3), .READ_LATENCY(3)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req32), .i_write(wr32), .i_address(addr32),
    .i_data(data32), .i_be(be32), .o_grant(grant32), .o_done(done32), .o_data(q32));

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] req, wr;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] be;
    logic [1:0] g, done;
    logic [7:0] q0, q1;
  } row_t;

  row_t tbl[17];

  function automatic row_t mk(logic [1:0] req, logic [1:0] wr, logic [3:0] a0, logic [3:0] a1,
                              logic [7:0] d0, logic [7:0] d1, logic [1:0] be,
                              logic [1:0] g, logic [1:0] done, logic [7:0] q0, logic [7:0] q1);
    row_t r;
    r.req = req; r.wr = wr; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1; r.be = be;
    r.g = g; r.done = done; r.q0 = q0; r.q1 = q1;
    return r;
  endfunction

  logic [2:0]  log_done [16];
  logic [95:0] log_q    [16];
  int          lk;
  logic [2:0]  expd [$];

  task automatic clear32();
    req32 = '0; wr32 = '0; addr32 = '0; data32 = '0; be32 = '0;
  endtask

  task automatic step32(input int p, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    clear32();
    if (p >= 0) begin
      req32[p] = 1'b1; wr32[p] = w; addr32[p*4 +: 4] = a;
      data32[p*32 +: 32] = d; be32[p*4 +: 4] = be;
    end
    #1 chk("step grant", grant32, (p >= 0) ? 3'(1 << p) : 3'b000);
    @(posedge clk);
    #1;
    log_done[lk] = done32;
    log_q[lk]    = q32;
    lk++;
  endtask

  task automatic chk_log(input string nm);
    for (int k = 0; k < expd.size(); k++)
      chk($sformatf("%s done[%0d]", nm, k), log_done[k], expd[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear32();
    req8 = '0; wr8 = '0; addr8 = '0; data8 = '0; be8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: memory image, per-port pending request, scheduled completions.
  logic [31:0] m_mem [16];
  logic [31:0] m_q   [3];
  logic [2:0]  s_done [8];
  logic [2:0]  s_rd   [8];
  logic [31:0] s_dat  [8][3];
  logic        pend [3];
  logic        p_wr [3];
  logic [3:0]  p_a  [3];
  logic [31:0] p_d  [3];
  logic [3:0]  p_be [3];
  int          waitc [3];

  task automatic run_random(input int ncyc);
    int g, q, slot, fill, t, m_ptr;
    logic filled;
    fill = 0; t = 0; m_ptr = 0; filled = 1'b0;
    for (int i = 0; i < 8; i++) begin s_done[i] = '0; s_rd[i] = '0; end
    for (int p = 0; p < 3; p++) begin m_q[p] = '0; pend[p] = 1'b0; waitc[p] = 0; end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (fill == 16 && !pend[0] && !pend[1] && !pend[2]) filled = 1'b1;
      for (int p = 0; p < 3; p++) begin
        if (!pend[p] && c < ncyc - 12 && $urandom_range(0, 99) < 60) begin
          if (fill < 16) begin
            pend[p] = 1'b1; p_wr[p] = 1'b1; p_a[p] = 4'(fill); p_be[p] = 4'hF; fill++;
          end else if (filled) begin
            pend[p] = 1'b1; p_wr[p] = 1'($urandom_range(0, 1));
            p_a[p] = 4'($urandom_range(0, 15)); p_be[p] = 4'($urandom_range(0, 15));
          end
          p_d[p] = $urandom; waitc[p] = 0;
        end
        req32[p] = pend[p]; wr32[p] = p_wr[p]; addr32[p*4 +: 4] = p_a[p];
        data32[p*32 +: 32] = p_d[p]; be32[p*4 +: 4] = p_be[p];
      end
      g = -1;
      for (int i = 0; i < 3; i++) begin
        q = (m_ptr + i) % 3;
        if (g < 0 && pend[q]) g = q;
      end
      #1 chk("rand grant", grant32, (g >= 0) ? 3'(1 << g) : 3'b000);
      @(posedge clk);
      t++;
      if (g >= 0) begin
        if (p_wr[g]) begin
          for (int b = 0; b < 4; b++)
            if (p_be[g][b]) m_mem[p_a[g]][b*8 +: 8] = p_d[g][b*8 +: 8];
          slot = (t + 1) % 8;
          s_done[slot][g] = 1'b1;
        end else begin
          slot = (t + 3) % 8;
          s_done[slot][g] = 1'b1;
          s_rd[slot][g]   = 1'b1;
          s_dat[slot][g]  = m_mem[p_a[g]];
        end
        chk("rand starvation", waitc[g] <= 2, 1'b1);
        pend[g] = 1'b0;
        m_ptr = (g + 1) % 3;
      end
      for (int p = 0; p < 3; p++) if (pend[p]) waitc[p]++;
      #1;
      slot = t % 8;
      for (int p = 0; p < 3; p++) if (s_rd[slot][p]) m_q[p] = s_dat[slot][p];
      chk("rand done", done32, s_done[slot]);
      chk("rand data", q32, {m_q[2], m_q[1], m_q[0]});
      s_done[slot] = '0;
      s_rd[slot]   = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req8 = 2'b11; wr8 = '0; addr8 = '0; data8 = '0; be8 = '0;
    clear32();
    req32 = 3'b111;
    #12;
    chk("reset grant8", grant8, 2'b00);
    chk("reset grant32", grant32, 3'b000);
    chk("reset done8", done8, 2'b00);
    chk("reset data8", q8, 16'h0);
    chk("reset done32", done32, 3'b000);
    chk("reset data32", q32, 96'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req8 = '0; clear32();

    //              req    wr     a0 a1 d0     d1     be     g      done   q0     q1
    tbl[0]  = mk(2'b11, 2'b11, 3, 7, 8'h5A, 8'hC3, 2'b11, 2'b01, 2'b00, 8'h00, 8'h00);
    tbl[1]  = mk(2'b11, 2'b11, 3, 7, 8'h5A, 8'hC3, 2'b11, 2'b10, 2'b01, 8'h00, 8'h00);
    tbl[2]  = mk(2'b11, 2'b11, 3, 7, 8'h5A, 8'hC3, 2'b11, 2'b01, 2'b10, 8'h00, 8'h00);
    tbl[3]  = mk(2'b11, 2'b11, 3, 7, 8'h5A, 8'hC3, 2'b11, 2'b10, 2'b01, 8'h00, 8'h00);
    tbl[4]  = mk(2'b11, 2'b11, 3, 7, 8'h5A, 8'hC3, 2'b11, 2'b01, 2'b10, 8'h00, 8'h00);
    tbl[5]  = mk(2'b11, 2'b11, 3, 7, 8'h5A, 8'hC3, 2'b11, 2'b10, 2'b01, 8'h00, 8'h00);
    tbl[6]  = mk(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 8'h00, 8'h00);
    tbl[7]  = mk(2'b01, 2'b01, 3, 0, 8'hFF, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00, 8'h00);
    tbl[8]  = mk(2'b01, 2'b00, 3, 0, 8'h00, 8'h00, 2'b01, 2'b01, 2'b01, 8'h00, 8'h00);
    tbl[9]  = mk(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 8'h5A, 8'h00);
    tbl[10] = mk(2'b01, 2'b01, 3, 0, 8'hA5, 8'h00, 2'b01, 2'b01, 2'b00, 8'h5A, 8'h00);
    tbl[11] = mk(2'b01, 2'b00, 3, 0, 8'h00, 8'h00, 2'b00, 2'b01, 2'b01, 8'h5A, 8'h00);
    tbl[12] = mk(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 8'hA5, 8'h00);
    tbl[13] = mk(2'b10, 2'b00, 0, 7, 8'h00, 8'h00, 2'b00, 2'b10, 2'b00, 8'hA5, 8'h00);
    tbl[14] = mk(2'b11, 2'b00, 3, 7, 8'h00, 8'h00, 2'b00, 2'b01, 2'b10, 8'hA5, 8'hC3);
    tbl[15] = mk(2'b11, 2'b00, 3, 7, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01, 8'hA5, 8'hC3);
    tbl[16] = mk(2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b10, 8'hA5, 8'hC3);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req8 = tbl[i].req; wr8 = tbl[i].wr; addr8 = {tbl[i].a1, tbl[i].a0};
      data8 = {tbl[i].d1, tbl[i].d0}; be8 = tbl[i].be;
      #1 chk($sformatf("row%0d grant", i), grant8, tbl[i].g);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d done", i), done8, tbl[i].done);
      chk($sformatf("row%0d data", i), q8, {tbl[i].q1, tbl[i].q0});
    end

    // Byte-enable merge on the wide instance.
    do_reset();
    lk = 0;
    step32(0, 1'b1, 4'd5, 32'h11223344, 4'hF);
    step32(0, 1'b1, 4'd5, 32'hAABBCCDD, 4'h5);
    step32(0, 1'b0, 4'd5, 32'h0, 4'h0);
    repeat (4) step32(-1, 1'b0, 4'd0, 32'h0, 4'h0);
    expd = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000};
    chk_log("bemerge");
    chk("bemerge data", log_q[5][31:0], 32'h11BB33DD);

    // Back-to-back latency-3 reads routed to ports 0,1,0.
    lk = 0;
    step32(0, 1'b1, 4'd1, 32'h01010101, 4'hF);
    step32(1, 1'b1, 4'd2, 32'h02020202, 4'hF);
    step32(0, 1'b0, 4'd1, 32'h0, 4'h0);
    step32(1, 1'b0, 4'd2, 32'h0, 4'h0);
    step32(0, 1'b0, 4'd5, 32'h0, 4'h0);
    repeat (4) step32(-1, 1'b0, 4'd0, 32'h0, 4'h0);
    expd = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 3'b001, 3'b010, 3'b001, 3'b000};
    chk_log("b2b");
    chk("b2b data p0 first", log_q[5][31:0], 32'h01010101);
    chk("b2b data p1", log_q[6][63:32], 32'h02020202);
    chk("b2b data p0 held", log_q[6][31:0], 32'h01010101);
    chk("b2b data p0 second", log_q[7][31:0], 32'h11BB33DD);

    // Read and write completions for port 0 landing together.
    lk = 0;
    step32(0, 1'b0, 4'd2, 32'h0, 4'h0);
    step32(-1, 1'b0, 4'd0, 32'h0, 4'h0);
    step32(0, 1'b1, 4'd9, 32'h12345678, 4'hF);
    repeat (2) step32(-1, 1'b0, 4'd0, 32'h0, 4'h0);
    expd = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    chk_log("merge");
    chk("merge data before", log_q[2][31:0], 32'h11BB33DD);
    chk("merge data after", log_q[3][31:0], 32'h02020202);

    // Reset with a read in flight.
    lk = 0;
    step32(0, 1'b0, 4'd1, 32'h0, 4'h0);
    step32(-1, 1'b0, 4'd0, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst async done", done32, 3'b000);
    chk("rst async data", q32, 96'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lk = 0;
    repeat (6) step32(-1, 1'b0, 4'd0, 32'h0, 4'h0);
    expd = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    chk_log("flush");
    for (int k = 0; k < 6; k++) chk($sformatf("flush data[%0d]", k), log_q[k], 96'h0);

    do_reset();
    run_random(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
